// File: rtl/reflex_responder_if.sv
// Handshake bundle between the automated reflex player and its controller/tester.
// The master side requests runs and models the tester LED; the slave side is the responder.
interface reflex_responder_if;
    logic        go;
    logic        cheat;
    logic [15:0] delay_ms;
    logic [7:0]  hold_ms;
    logic        led;
    logic        start;
    logic        button;
    logic        busy;
    logic        done;
    logic        timeout;

    modport master (
        output go, cheat, delay_ms, hold_ms, led,
        input  start, button, busy, done, timeout
    );

    modport slave (
        input  go, cheat, delay_ms, hold_ms, led,
        output start, button, busy, done, timeout
    );
endinterface

// File: rtl/reflex_responder.sv
// Automated reflex-tester player: pulses start, waits for the LED (or not, in cheat mode),
// waits a programmable delay, then holds the button for a programmable time.
module reflex_responder #(
    parameter int TICKS_PER_MS = 50000,
    parameter int START_CYCLES = 4,
    parameter int TIMEOUT_MS   = 10000
) (
    input  logic               clk,
    input  logic               reset,
    reflex_responder_if.slave  bus
);
    localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST    = TW'(TICKS_PER_MS - 1);
    localparam logic [SW-1:0] START_LAST   = SW'(START_CYCLES - 1);
    localparam logic [15:0]   TIMEOUT_LAST = 16'(TIMEOUT_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_LED = 3'd2,
        S_DELAY    = 3'd3,
        S_PRESS    = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d, tick_adv_s;
    logic [15:0]     ms_q, ms_d, ms_adv_s;
    logic [SW-1:0]   start_cnt_q, start_cnt_d;
    logic            cheat_q, cheat_d;
    logic [15:0]     delay_q, delay_d;
    logic [7:0]      hold_q, hold_d;
    logic [15:0]     hold_last_s;
    logic            led_meta_q, led_sync_q;
    logic            start_q, start_d;
    logic            button_q, button_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;

    assign bus.start   = start_q;
    assign bus.button  = button_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;

    // Millisecond prescaler step: ms_adv_s advances once per TICKS_PER_MS cycles.
    always_comb begin
        if (tick_q == TICK_LAST) begin
            tick_adv_s = {TW{1'b0}};
            ms_adv_s   = ms_q + 16'd1;
        end else begin
            tick_adv_s = tick_q + TW'(1);
            ms_adv_s   = ms_q;
        end
    end

    // A hold of 0 ms behaves like 1 ms, so the last ms index is max(hold,1)-1.
    always_comb begin
        if (hold_q == 8'd0) begin
            hold_last_s = 16'd0;
        end else begin
            hold_last_s = {8'd0, hold_q} - 16'd1;
        end
    end

    // Next-state logic; every timed state entry clears the prescaler.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        ms_d        = ms_q;
        start_cnt_d = start_cnt_q;
        cheat_d     = cheat_q;
        delay_d     = delay_q;
        hold_d      = hold_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    cheat_d     = bus.cheat;
                    delay_d     = bus.delay_ms;
                    hold_d      = bus.hold_ms;
                    timeout_d   = 1'b0;
                    start_cnt_d = {SW{1'b0}};
                    state_d     = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (start_cnt_q == START_LAST) begin
                    tick_d  = {TW{1'b0}};
                    ms_d    = 16'd0;
                    state_d = cheat_q ? S_DELAY : S_WAIT_LED;
                end else begin
                    start_cnt_d = start_cnt_q + SW'(1);
                end
            end
            S_WAIT_LED: begin
                if (led_sync_q) begin
                    tick_d  = {TW{1'b0}};
                    ms_d    = 16'd0;
                    state_d = S_DELAY;
                end else if ((tick_q == TICK_LAST) && (ms_q == TIMEOUT_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tick_d = tick_adv_s;
                    ms_d   = ms_adv_s;
                end
            end
            S_DELAY: begin
                // Checked at tick 0 of each ms, so delay 0 leaves after one cycle.
                if (ms_q == delay_q) begin
                    tick_d  = {TW{1'b0}};
                    ms_d    = 16'd0;
                    state_d = S_PRESS;
                end else begin
                    tick_d = tick_adv_s;
                    ms_d   = ms_adv_s;
                end
            end
            S_PRESS: begin
                if ((tick_q == TICK_LAST) && (ms_q == hold_last_s)) begin
                    state_d = S_FINISH;
                end else begin
                    tick_d = tick_adv_s;
                    ms_d   = ms_adv_s;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        start_d  = (state_d == S_START);
        button_d = (state_d == S_PRESS);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FINISH);
    end

    // State, counters, latched run fields, LED synchronizer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_q      <= {TW{1'b0}};
            ms_q        <= 16'd0;
            start_cnt_q <= {SW{1'b0}};
            cheat_q     <= 1'b0;
            delay_q     <= 16'd0;
            hold_q      <= 8'd0;
            led_meta_q  <= 1'b0;
            led_sync_q  <= 1'b0;
            start_q     <= 1'b0;
            button_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            ms_q        <= ms_d;
            start_cnt_q <= start_cnt_d;
            cheat_q     <= cheat_d;
            delay_q     <= delay_d;
            hold_q      <= hold_d;
            led_meta_q  <= bus.led;
            led_sync_q  <= led_meta_q;
            start_q     <= start_d;
            button_q    <= button_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end
endmodule

// File: tb/tb_reflex_responder.sv
// Scoreboard bench for reflex_responder: each launched run pushes its expected timing,
// and the monitor pops and compares it when the run's done pulse appears.
module tb_reflex_responder;
    localparam int TPM = 4;
    localparam int SC  = 3;
    localparam int TMO = 20;

    typedef struct {
        int start_w;
        bit ref_start;
        int lat;
        int btn_w;
        bit pressed;
        bit to;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    reflex_responder_if bus();

    reflex_responder #(.TICKS_PER_MS(TPM), .START_CYCLES(SC), .TIMEOUT_MS(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   ref_cyc = 0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor state
    bit   start_p, btn_p, done_p, pressed;
    int   start_rise, start_fall, btn_rise, btn_last;
    exp_t me;

    always @(negedge clk) begin
        if (reset) begin
            start_p = 1'b0;
            btn_p   = 1'b0;
            done_p  = 1'b0;
        end else begin
            if (bus.start && !start_p) begin
                start_rise = cyc;
                pressed    = 1'b0;
                check_eq("timeout_clear", int'(bus.timeout), 0);
            end
            if (!bus.start && start_p) start_fall = cyc;
            if (bus.button && !btn_p) begin
                btn_rise = cyc;
                pressed  = 1'b1;
            end
            if (bus.button) btn_last = cyc;
            if (done_p) check_eq("done_width", int'(bus.done), 0);
            if (bus.done) begin
                done_cnt++;
                check_eq("busy_finish", int'(bus.busy), 1);
                if (sb.size() == 0) begin
                    check_eq("unexpected_done", 1, 0);
                end else begin
                    me = sb.pop_front();
                    check_eq("start_width", start_fall - start_rise, me.start_w);
                    check_eq("pressed", int'(pressed), int'(me.pressed));
                    check_eq("timeout_flag", int'(bus.timeout), int'(me.to));
                    if (me.pressed) begin
                        check_eq("button_latency", btn_rise - (me.ref_start ? start_fall : ref_cyc), me.lat);
                        check_eq("button_width", btn_last + 1 - btn_rise, me.btn_w);
                        check_eq("done_gap", cyc - btn_last, 1);
                    end else begin
                        check_eq("done_latency", cyc - (me.ref_start ? start_fall : ref_cyc), me.lat);
                    end
                end
            end
            start_p = bus.start;
            btn_p   = bus.button;
            done_p  = bus.done;
        end
    end

    function automatic int hold_cycles(input int h);
        return ((h == 0) ? 1 : h) * TPM;
    endfunction

    task automatic push_exp(input bit ref_start, input int lat, input int btn_w,
                            input bit pr, input bit to);
        exp_t e;
        e.start_w   = SC;
        e.ref_start = ref_start;
        e.lat       = lat;
        e.btn_w     = btn_w;
        e.pressed   = pr;
        e.to        = to;
        sb.push_back(e);
    endtask

    task automatic launch(input bit c, input int d, input int h);
        @(negedge clk);
        bus.go       = 1'b1;
        bus.cheat    = c;
        bus.delay_ms = 16'(d);
        bus.hold_ms  = 8'(h);
        @(negedge clk);
        bus.go = 1'b0;
    endtask

    task automatic led_after(input int n);
        repeat (n) @(negedge clk);
        bus.led = 1'b1;
        ref_cyc = cyc;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < target) check_eq("wait_done", done_cnt, target);
        @(negedge clk);
        bus.led = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.go = 1'b0; bus.cheat = 1'b0; bus.delay_ms = 16'd0; bus.hold_ms = 8'd0; bus.led = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_start", int'(bus.start), 0);
        check_eq("rst_button", int'(bus.button), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        check_eq("rst_done", int'(bus.done), 0);
        check_eq("rst_timeout", int'(bus.timeout), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", int'(bus.busy), 0);

        // Normal run: delay 5 ms, hold 2 ms, LED 40 cycles after go
        push_exp(1'b0, 3 + 5 * TPM + 1, hold_cycles(2), 1'b1, 1'b0);
        launch(1'b0, 5, 2);
        led_after(39);
        wait_done(1, 300);

        // Zero delay and zero hold
        push_exp(1'b0, 4, hold_cycles(0), 1'b1, 1'b0);
        launch(1'b0, 0, 0);
        led_after(10);
        wait_done(2, 300);

        // Cheat mode: LED never rises, button follows the start pulse
        push_exp(1'b1, 1 * TPM + 1, hold_cycles(3), 1'b1, 1'b0);
        launch(1'b1, 1, 3);
        wait_done(3, 300);

        // LED timeout
        push_exp(1'b1, TMO * TPM, 0, 1'b0, 1'b1);
        launch(1'b0, 3, 1);
        wait_done(4, 300);
        check_eq("timeout_hold", int'(bus.timeout), 1);
        check_eq("timeout_idle_busy", int'(bus.busy), 0);

        // Ignored go during DELAY with a different delay_ms
        push_exp(1'b0, 3 + 2 * TPM + 1, hold_cycles(1), 1'b1, 1'b0);
        launch(1'b0, 2, 1);
        led_after(10);
        repeat (6) @(negedge clk);
        bus.go = 1'b1;
        bus.delay_ms = 16'd9;
        @(negedge clk);
        bus.go = 1'b0;
        wait_done(5, 300);
        check_eq("single_done", done_cnt, 5);

        // Reset mid-press: no done expected for this run
        launch(1'b0, 1, 3);
        led_after(5);
        begin
            int n = 0;
            while (!bus.button && n < 100) begin
                @(posedge clk);
                n++;
            end
            check_eq("button_seen", int'(bus.button), 1);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("async_button", int'(bus.button), 0);
        check_eq("async_busy", int'(bus.busy), 0);
        check_eq("async_start", int'(bus.start), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.led = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_done", int'(bus.done), 0);

        // Clean run after reset
        push_exp(1'b0, 3 + 1 * TPM + 1, hold_cycles(1), 1'b1, 1'b0);
        launch(1'b0, 1, 1);
        led_after(8);
        wait_done(6, 300);

        check_eq("sb_empty", sb.size(), 0);
        check_eq("done_total", done_cnt, 6);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
